// File: rtl/pass_keeper_ctrl.sv
// Password-keeper sequencer: boots the CAM from flash, then runs retrieve/store
// operations through CAM lookup, cipher and flash write, with a per-wait timeout.
module pass_keeper_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] max_add,
    input  logic              match,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic              enc_done,
    input  logic              dec_done,
    output logic              cam_start,
    output logic              cam_write_en,
    output logic              start_enc,
    output logic              start_dec,
    output logic              flash_write_en,
    output logic [ADDR_W-1:0] address_out,
    output logic              busy,
    output logic              boot_done,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int N  = 2**ADDR_W;
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   T_ONE    = TW'(1);

    localparam logic [1:0] ERR_OP   = 2'b00;
    localparam logic [1:0] ERR_NF   = 2'b01;
    localparam logic [1:0] ERR_FULL = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    typedef enum logic [2:0] {
        S_BOOT, S_IDLE, S_SEARCH, S_CAMWAIT, S_ENC_WAIT, S_DEC_WAIT, S_WRITE, S_FIN
    } state_t;

    state_t            state;
    logic              is_store;
    logic              new_entry;
    logic [ADDR_W:0]   count;
    logic [TW-1:0]     tcnt;
    logic [ADDR_W-1:0] boot_addr;

    // Outputs are registered on entry to the state that owns them, so each
    // strobe is visible for exactly the cycle spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_BOOT;
            address_out    <= '0;
            cam_start      <= 1'b0;
            cam_write_en   <= 1'b0;
            start_enc      <= 1'b0;
            start_dec      <= 1'b0;
            flash_write_en <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= ERR_OP;
            busy           <= 1'b1;
            boot_done      <= 1'b0;
            count          <= '0;
            tcnt           <= '0;
            boot_addr      <= '0;
            is_store       <= 1'b0;
            new_entry      <= 1'b0;
        end else begin
            cam_start      <= 1'b0;
            cam_write_en   <= 1'b0;
            start_enc      <= 1'b0;
            start_dec      <= 1'b0;
            flash_write_en <= 1'b0;
            done           <= 1'b0;

            case (state)
                S_BOOT: begin
                    cam_write_en <= 1'b1;
                    address_out  <= boot_addr;
                    if (boot_addr == max_add) begin
                        boot_done <= 1'b1;
                        count     <= {1'b0, max_add} + CNT_ONE;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        boot_addr <= boot_addr + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (go) begin
                        busy <= 1'b1;
                        if (op[1]) begin
                            done     <= 1'b1;
                            error    <= 1'b1;
                            err_code <= ERR_OP;
                            state    <= S_FIN;
                        end else begin
                            is_store  <= op[0];
                            cam_start <= 1'b1;
                            state     <= S_SEARCH;
                        end
                    end
                end

                S_SEARCH: state <= S_CAMWAIT;

                S_CAMWAIT: begin
                    tcnt <= '0;
                    if (!is_store) begin
                        if (match) begin
                            address_out <= match_addr;
                            start_dec   <= 1'b1;
                            state       <= S_DEC_WAIT;
                        end else begin
                            done     <= 1'b1;
                            error    <= 1'b1;
                            err_code <= ERR_NF;
                            state    <= S_FIN;
                        end
                    end else if (match) begin
                        address_out <= match_addr;
                        new_entry   <= 1'b0;
                        start_enc   <= 1'b1;
                        state       <= S_ENC_WAIT;
                    end else if (count < CNT_FULL) begin
                        address_out <= count[ADDR_W-1:0];
                        new_entry   <= 1'b1;
                        start_enc   <= 1'b1;
                        state       <= S_ENC_WAIT;
                    end else begin
                        done     <= 1'b1;
                        error    <= 1'b1;
                        err_code <= ERR_FULL;
                        state    <= S_FIN;
                    end
                end

                // Completion is tested before the timeout so a late pulse still wins.
                S_DEC_WAIT: begin
                    if (dec_done) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else if (tcnt == T_LAST) begin
                        done     <= 1'b1;
                        error    <= 1'b1;
                        err_code <= ERR_TO;
                        state    <= S_FIN;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end

                S_ENC_WAIT: begin
                    if (enc_done) begin
                        flash_write_en <= 1'b1;
                        cam_write_en   <= 1'b1;
                        state          <= S_WRITE;
                    end else if (tcnt == T_LAST) begin
                        done     <= 1'b1;
                        error    <= 1'b1;
                        err_code <= ERR_TO;
                        state    <= S_FIN;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end

                S_WRITE: begin
                    if (new_entry && (count < CNT_FULL))
                        count <= count + CNT_ONE;
                    done  <= 1'b1;
                    state <= S_FIN;
                end

                S_FIN: begin
                    error    <= 1'b0;
                    err_code <= ERR_OP;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pass_keeper_ctrl.sv
// Randomized bench for pass_keeper_ctrl: the bench plays CAM and cipher and
// predicts each operation's outcome and latency from a transaction-level model.
module tb_pass_keeper_ctrl;

    localparam int AW = 4;
    localparam int TO = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst, go, match, enc_done, dec_done;
    logic [1:0]    op;
    logic [AW-1:0] max_add, match_addr;
    logic          cam_start, cam_write_en, start_enc, start_dec, flash_write_en;
    logic [AW-1:0] address_out;
    logic          busy, boot_done, done, error;
    logic [1:0]    err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int model_count;

    pass_keeper_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .go(go), .op(op), .max_add(max_add),
        .match(match), .match_addr(match_addr), .enc_done(enc_done), .dec_done(dec_done),
        .cam_start(cam_start), .cam_write_en(cam_write_en), .start_enc(start_enc),
        .start_dec(start_dec), .flash_write_en(flash_write_en), .address_out(address_out),
        .busy(busy), .boot_done(boot_done), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, {cam_start, cam_write_en, start_enc, start_dec, flash_write_en}, 0);
        chk({tag, "_addr"}, address_out, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_boot_done"}, boot_done, 0);
        chk({tag, "_done_err"}, {done, error, err_code}, 0);
    endtask

    task automatic do_boot(input int m);
        rst = 1'b1; go = 1'b0; enc_done = 1'b0; dec_done = 1'b0; match = 1'b0;
        op = 2'b00; match_addr = '0; max_add = AW'(m);
        tick; tick;
        chk_reset("rst");
        rst = 1'b0;
        for (int a = 0; a <= m; a++) begin
            tick;
            chk("boot_we", cam_write_en, 1);
            chk("boot_addr", address_out, a);
        end
        tick;
        chk("boot_we_end", cam_write_en, 0);
        chk("boot_done", boot_done, 1);
        chk("boot_busy", busy, 0);
        model_count = m + 1;
    endtask

    // dly: wait-state cycle (1 = same cycle as the start strobe) in which the
    // cipher answers; anything past TO means the cipher never answers in time.
    task automatic run_op(input logic [1:0] o, input logic m, input logic [AW-1:0] ma,
                          input int dly, input string tag);
        int exp_lat = 0, exp_kind = 0, exp_addr = 0;
        logic exp_err = 1'b0, exp_wr = 1'b0;
        logic [1:0] exp_code = 2'b00;
        int got_lat = -1, kind = 0, w = 0, n_cs = 0, n_sd = 0, n_se = 0, n_wr = 0;
        int got_saddr = -1, got_waddr = -1, ovl = 0, bsy = 0, s;
        logic prev_cs = 1'b0, got_err = 1'b0;
        logic [1:0] got_code = 2'b00;

        if (o[1]) begin
            exp_lat = 1; exp_err = 1'b1; exp_code = 2'b00;
        end else if (o == 2'b00) begin
            if (!m) begin
                exp_lat = 3; exp_err = 1'b1; exp_code = 2'b01;
            end else begin
                exp_kind = 1; exp_addr = ma;
                if (dly <= TO) exp_lat = 3 + dly;
                else begin exp_lat = 3 + TO; exp_err = 1'b1; exp_code = 2'b11; end
            end
        end else begin
            if (!m && model_count >= N) begin
                exp_lat = 3; exp_err = 1'b1; exp_code = 2'b10;
            end else begin
                exp_kind = 2;
                exp_addr = m ? int'(ma) : model_count;
                if (dly <= TO) begin exp_lat = 4 + dly; exp_wr = 1'b1; end
                else begin exp_lat = 3 + TO; exp_err = 1'b1; exp_code = 2'b11; end
            end
        end
        if (exp_wr && !m) model_count++;

        chk({tag, "_idle"}, busy, 0);
        go = 1'b1; op = o;
        for (int c = 1; c <= 40 && got_lat < 0; c++) begin
            tick;
            go = 1'($urandom_range(0, 1));
            op = 2'($urandom);
            max_add = AW'($urandom);
            match      = prev_cs ? m  : 1'($urandom);
            match_addr = prev_cs ? ma : AW'($urandom);
            prev_cs = cam_start;
            n_cs += int'(cam_start);
            if (start_dec || start_enc) begin
                w = 1; kind = start_dec ? 1 : 2; got_saddr = address_out;
                n_sd += int'(start_dec); n_se += int'(start_enc);
            end else if (w > 0) begin
                w++;
            end
            if (w == 0) begin
                dec_done = 1'($urandom_range(0, 1));
                enc_done = 1'($urandom_range(0, 1));
            end else if (kind == 1) begin
                dec_done = (w == dly);
                enc_done = 1'($urandom_range(0, 1));
            end else begin
                enc_done = (w == dly);
                dec_done = 1'($urandom_range(0, 1));
            end
            if (flash_write_en) begin
                n_wr++; got_waddr = address_out;
                if (!cam_write_en) ovl++;
            end
            s = int'(cam_start) + int'(start_enc) + int'(start_dec) + int'(flash_write_en | cam_write_en);
            if (s > 1 || (cam_write_en && !flash_write_en)) ovl++;
            if (!busy) bsy++;
            if (done) begin
                got_lat = c; got_err = error; got_code = err_code;
            end
        end
        go = 1'b0; enc_done = 1'b0; dec_done = 1'b0;

        chk({tag, "_lat"}, got_lat, exp_lat);
        chk({tag, "_err"}, got_err, exp_err);
        if (exp_err) chk({tag, "_code"}, got_code, exp_code);
        chk({tag, "_cam_start"}, n_cs, o[1] ? 0 : 1);
        chk({tag, "_start_dec"}, n_sd, exp_kind == 1 ? 1 : 0);
        chk({tag, "_start_enc"}, n_se, exp_kind == 2 ? 1 : 0);
        if (exp_kind != 0) chk({tag, "_start_addr"}, got_saddr, exp_addr);
        chk({tag, "_writes"}, n_wr, exp_wr ? 1 : 0);
        if (exp_wr) chk({tag, "_write_addr"}, got_waddr, exp_addr);
        chk({tag, "_overlap"}, ovl, 0);
        chk({tag, "_busy_low"}, bsy, 0);
        tick;
        chk({tag, "_after"}, {done, busy}, 0);
    endtask

    task automatic reset_in_enc_wait;
        int seen = 0;
        go = 1'b1; op = 2'b01;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            tick;
            go = 1'b0; match = 1'b0;
            if (start_enc) seen = 1;
        end
        chk("mid_rst_reached_enc", seen, 1);
        tick;
        rst = 1'b1; enc_done = 1'b1;
        tick;
        chk_reset("mid_rst");
        enc_done = 1'b0;
        tick;
        chk("mid_rst_no_write", flash_write_en, 0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; op = 2'b00; max_add = '0; match = 1'b0;
        match_addr = '0; enc_done = 1'b0; dec_done = 1'b0;

        do_boot(3);
        run_op(2'b01, 1'b0, 4'd0, 2, "store_new4");
        run_op(2'b01, 1'b0, 4'd0, 3, "store_new5");
        run_op(2'b00, 1'b1, 4'd2, 6, "ret_match2");
        run_op(2'b00, 1'b1, 4'd7, 1, "ret_min_lat");
        run_op(2'b00, 1'b1, 4'd1, 9, "ret_timeout");
        run_op(2'b00, 1'b1, 4'd1, 8, "ret_edge");
        run_op(2'b01, 1'b1, 4'd3, 10, "store_timeout");
        run_op(2'b11, 1'b0, 4'd0, 1, "bad_op11");
        run_op(2'b10, 1'b0, 4'd0, 1, "bad_op10");
        run_op(2'b00, 1'b0, 4'd0, 1, "ret_miss");
        run_op(2'b01, 1'b0, 4'd0, 1, "store_new6");

        reset_in_enc_wait();
        do_boot(15);
        run_op(2'b01, 1'b0, 4'd0, 2, "store_full");
        run_op(2'b01, 1'b1, 4'd9, 2, "store_hit_full");

        for (int b = 0; b < 3; b++) begin
            do_boot(int'($urandom_range(0, 15)));
            for (int k = 0; k < 25; k++) begin
                int sel;
                logic [1:0] o;
                sel = int'($urandom_range(0, 9));
                o = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : 2'($urandom_range(2, 3));
                run_op(o, 1'($urandom_range(0, 1)), AW'($urandom),
                       int'($urandom_range(1, 10)), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pass_keeper_ctrl.md
PASS_KEEPER_CTRL -- requirements
Module: pass_keeper_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: CAM/flash entry address width; capacity N = 2**ADDR_W entries.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for enc_done/dec_done; counter width = clog2(TIMEOUT+1).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 go  in  1  operation request; sampled only in IDLE.
REQ-006 op  in  2  sampled with go: 00 retrieve, 01 store, 10/11 reserved.
REQ-007 max_add  in  ADDR_W  highest address holding a valid entry at boot.
REQ-008 match  in  1  CAM hit; valid the cycle after cam_start.
REQ-009 match_addr  in  ADDR_W  CAM hit address; valid with match.
REQ-010 enc_done, dec_done  in  1 each  single-cycle completion pulses from the cipher.
REQ-011 cam_start, cam_write_en, start_enc, start_dec, flash_write_en  out  1 each  single-cycle strobes.
REQ-012 address_out  out  ADDR_W  registered address to CAM/flash.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 boot_done  out  1  sticky once boot completes; cleared only by rst.
REQ-015 done  out  1  one-cycle pulse at end of every accepted operation, including failed ones.
REQ-016 error  out  1; err_code  out  2  error qualifies done; codes 00 bad op, 01 not found, 10 full, 11 timeout.

Function
REQ-017 States: BOOT, IDLE, SEARCH, CAMWAIT, ENC_WAIT, DEC_WAIT, WRITE, FIN.
REQ-018 BOOT: one cycle per address a = 0..max_add: address_out=a, cam_write_en=1; after a==max_add, set boot_done, count=max_add+1, next IDLE. Boot takes max_add+1 cycles.
REQ-019 IDLE: go=1 with op 00/01 -> SEARCH; go=1 with op 10/11 -> FIN with error=1, err_code=00. go=0 -> stay. go is ignored outside IDLE.
REQ-020 SEARCH: cam_start=1 for exactly one cycle -> CAMWAIT.
REQ-021 CAMWAIT retrieve: match=1 -> address_out=match_addr, start_dec pulse, DEC_WAIT. match=0 -> FIN, err_code=01.
REQ-022 CAMWAIT store: match=1 -> target=match_addr. match=0 and count<N -> target=count[ADDR_W-1:0]. match=0 and count==N -> FIN, err_code=10. Otherwise address_out=target, start_enc pulse, ENC_WAIT.
REQ-023 DEC_WAIT: dec_done -> FIN, no error. ENC_WAIT: enc_done -> WRITE.
REQ-024 Timeout: counter clears on wait-state entry and increments each wait cycle. On reaching TIMEOUT without done -> FIN, err_code=11. A done arriving in the same cycle as the timeout wins.
REQ-025 WRITE: flash_write_en=1 and cam_write_en=1 for one cycle at address_out; count increments only when the store is a new entry (no match); -> FIN.
REQ-026 FIN: done=1 (error/err_code valid) for one cycle -> IDLE. Minimum go-to-done latency for a retrieve with dec_done arriving immediately is 4 cycles.
REQ-027 count is ADDR_W+1 bits wide and saturates at N; max_add is sampled only during BOOT.
REQ-028 Strobes never overlap, except that flash_write_en and cam_write_en are asserted together in WRITE.
REQ-029 Stray enc_done/dec_done outside the matching wait state are ignored.

Reset
REQ-030 rst=1 in any state, including mid-operation, on the next edge: state=BOOT, address_out=0, all strobes=0, done=0, error=0, err_code=00, busy=1, boot_done=0, count=0, timeout counter=0; boot reruns after rst falls.

Verification
REQ-031 rst then max_add=3 -> cam_write_en high 4 cycles at addresses 0,1,2,3 -> boot_done=1, busy=0.
REQ-032 Retrieve: match=1, match_addr=2, dec_done 5 cycles after start_dec -> address_out=2, done=1, error=0.
REQ-033 Store with match=0 after boot with max_add=3 -> WRITE at address 4, flash_write_en+cam_write_en one cycle, count=5. With ADDR_W=2 and max_add=3 -> done, error=1, err_code=10.
REQ-034 Retrieve with dec_done never arriving, TIMEOUT=8 -> done with err_code=11 after 8 DEC_WAIT cycles. Repeat with dec_done on the 8th cycle -> no error.
REQ-035 go with op=11 -> done, error=1, err_code=00. go pulsed while busy -> ignored.
REQ-036 rst asserted during ENC_WAIT -> the next cycle is BOOT with all outputs at reset values, and no WRITE occurs.
